// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with a valid/ready handshake, an optional 2-entry skid buffer,
// a synchronous flush and a saturating bubble counter.
module idex_pipe_reg #(
  parameter int unsigned CTRL_W = 22,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 9,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_pb,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_pb,
  output logic [IMM_W-1:0]  out_imm,
  output logic [PC_W-1:0]   out_pc,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_count
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] pb;
    logic [IMM_W-1:0]  imm;
    logic [PC_W-1:0]   pc;
  } pay_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  pay_t             main_q, main_d;
  pay_t             skid_q, skid_d;
  pay_t             in_pay;
  logic [CNT_W-1:0] bub_q, bub_d;
  logic             in_xfer, out_xfer;

  assign in_pay    = '{ctrl: in_ctrl, a: in_a, b: in_b, pb: in_pb, imm: in_imm, pc: in_pc};
  assign out_valid = (state_q != EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // With the skid buffer, in_ready depends only on registered state; without it, it looks through to out_ready.
  generate
    if (SKID != 0) begin : g_skid_ready
      assign in_ready = (state_q != FULL);
    end else begin : g_flat_ready
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = in_pay;
          state_d = MAIN;
        end
      end
      MAIN: begin
        if (in_xfer && out_xfer) begin
          main_d = in_pay;
        end else if (in_xfer && (SKID != 0)) begin
          skid_d  = in_pay;
          state_d = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = MAIN;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops every entry and any same-cycle input; data registers keep their old contents.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_comb begin
    bub_d = bub_q;
    if (!out_valid && out_ready && (bub_q != '1)) bub_d = bub_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      bub_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      bub_q   <= bub_d;
    end
  end

  assign out_ctrl     = out_valid ? main_q.ctrl : '0;
  assign out_a        = main_q.a;
  assign out_b        = main_q.b;
  assign out_pb       = main_q.pb;
  assign out_imm      = main_q.imm;
  assign out_pc       = main_q.pc;
  assign occupancy    = state_q;
  assign bubble_count = bub_q;

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Directed bench for idex_pipe_reg: a skid build (small bubble counter) and a flat build share inputs.
module tb_idex_pipe_reg;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, out_ready;
  logic [21:0] in_ctrl;
  logic [31:0] in_a, in_b, in_pb;
  logic [15:0] in_imm;
  logic [8:0]  in_pc;

  logic        in_ready1, out_valid1;
  logic [21:0] out_ctrl1;
  logic [31:0] out_a1, out_b1, out_pb1;
  logic [15:0] out_imm1;
  logic [8:0]  out_pc1;
  logic [1:0]  occ1;
  logic [1:0]  bub1;

  logic        in_ready0, out_valid0;
  logic [21:0] out_ctrl0;
  logic [31:0] out_a0, out_b0, out_pb0;
  logic [15:0] out_imm0;
  logic [8:0]  out_pc0;
  logic [1:0]  occ0;
  logic [15:0] bub0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  idex_pipe_reg #(.SKID(1), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_ctrl(in_ctrl), .in_a(in_a), .in_b(in_b), .in_pb(in_pb), .in_imm(in_imm), .in_pc(in_pc),
    .flush(flush), .out_valid(out_valid1), .out_ready(out_ready),
    .out_ctrl(out_ctrl1), .out_a(out_a1), .out_b(out_b1), .out_pb(out_pb1),
    .out_imm(out_imm1), .out_pc(out_pc1), .occupancy(occ1), .bubble_count(bub1)
  );

  idex_pipe_reg #(.SKID(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_ctrl(in_ctrl), .in_a(in_a), .in_b(in_b), .in_pb(in_pb), .in_imm(in_imm), .in_pc(in_pc),
    .flush(flush), .out_valid(out_valid0), .out_ready(out_ready),
    .out_ctrl(out_ctrl0), .out_a(out_a0), .out_b(out_b0), .out_pb(out_pb0),
    .out_imm(out_imm0), .out_pc(out_pc0), .occupancy(occ0), .bubble_count(bub0)
  );

  function automatic logic [21:0] ctrl_of(input logic [8:0] pc);
    return 22'h200000 | 22'(pc);
  endfunction
  function automatic logic [31:0] a_of(input logic [8:0] pc);
    return 32'h9F + 32'(pc);
  endfunction
  function automatic logic [31:0] b_of(input logic [8:0] pc);
    return 32'hB000_0000 | 32'(pc);
  endfunction
  function automatic logic [31:0] pb_of(input logic [8:0] pc);
    return 32'h5000_0000 + 32'(pc);
  endfunction
  function automatic logic [15:0] imm_of(input logic [8:0] pc);
    return 16'h8000 | 16'(pc);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic rdy, input logic fl, input logic [8:0] pc);
    in_valid  = iv;
    out_ready = rdy;
    flush     = fl;
    in_pc     = pc;
    in_ctrl   = ctrl_of(pc);
    in_a      = a_of(pc);
    in_b      = b_of(pc);
    in_pb     = pb_of(pc);
    in_imm    = imm_of(pc);
  endtask

  typedef struct {
    logic       iv;
    logic       rdy;
    logic       fl;
    logic [8:0] pc;
    logic       ov;
    logic [8:0] opc;
    logic [1:0] occ;
    logic       ir;
  } vec_t;

  vec_t tv[17];
  logic [1:0] bub_exp[5];

  initial begin
    // streaming
    tv[0]  = '{1'b1, 1'b1, 1'b0, 9'd1,  1'b1, 9'd1,  2'd1, 1'b1};
    tv[1]  = '{1'b1, 1'b1, 1'b0, 9'd2,  1'b1, 9'd2,  2'd1, 1'b1};
    tv[2]  = '{1'b1, 1'b1, 1'b0, 9'd3,  1'b1, 9'd3,  2'd1, 1'b1};
    tv[3]  = '{1'b1, 1'b1, 1'b0, 9'd4,  1'b1, 9'd4,  2'd1, 1'b1};
    tv[4]  = '{1'b0, 1'b1, 1'b0, 9'd0,  1'b0, 9'd0,  2'd0, 1'b1};
    // stall into skid, refused input while full, drain in order
    tv[5]  = '{1'b1, 1'b0, 1'b0, 9'd5,  1'b1, 9'd5,  2'd1, 1'b1};
    tv[6]  = '{1'b1, 1'b0, 1'b0, 9'd6,  1'b1, 9'd5,  2'd2, 1'b0};
    tv[7]  = '{1'b1, 1'b0, 1'b0, 9'h1F, 1'b1, 9'd5,  2'd2, 1'b0};
    tv[8]  = '{1'b0, 1'b1, 1'b0, 9'd0,  1'b1, 9'd6,  2'd1, 1'b1};
    tv[9]  = '{1'b0, 1'b1, 1'b0, 9'd0,  1'b0, 9'd0,  2'd0, 1'b1};
    // flush from FULL, then flush discarding an accepted input
    tv[10] = '{1'b1, 1'b0, 1'b0, 9'd7,  1'b1, 9'd7,  2'd1, 1'b1};
    tv[11] = '{1'b1, 1'b0, 1'b0, 9'd8,  1'b1, 9'd7,  2'd2, 1'b0};
    tv[12] = '{1'b1, 1'b0, 1'b1, 9'd9,  1'b0, 9'd0,  2'd0, 1'b1};
    tv[13] = '{1'b1, 1'b0, 1'b0, 9'd10, 1'b1, 9'd10, 2'd1, 1'b1};
    tv[14] = '{1'b1, 1'b1, 1'b1, 9'd11, 1'b0, 9'd0,  2'd0, 1'b1};
    tv[15] = '{1'b0, 1'b1, 1'b0, 9'd0,  1'b0, 9'd0,  2'd0, 1'b1};
    tv[16] = '{1'b1, 1'b1, 1'b0, 9'd12, 1'b1, 9'd12, 2'd1, 1'b1};
    bub_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    // reset with a valid all-ones input held at the inputs
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 9'h1FF);
    in_ctrl = 22'h3FFFFF;
    tick();
    tick();
    chk("rst_out_valid", out_valid1, 0);
    chk("rst_out_ctrl", out_ctrl1, 0);
    chk("rst_occupancy", occ1, 0);
    chk("rst_in_ready", in_ready1, 1);
    chk("rst_bubble", bub1, 0);
    chk("rst_out_a", out_a1, 0);
    chk("rst_out_pc", out_pc1, 0);
    chk("rst0_out_valid", out_valid0, 0);
    chk("rst0_in_ready", in_ready0, 1);

    // bubble counter saturates at 3 with CNT_W=2
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 9'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bubble_%0d", i), bub1, bub_exp[i]);
    end

    for (int i = 0; i < 17; i++) begin
      drive(tv[i].iv, tv[i].rdy, tv[i].fl, tv[i].pc);
      tick();
      chk($sformatf("v%0d_out_valid", i), out_valid1, tv[i].ov);
      chk($sformatf("v%0d_occupancy", i), occ1, tv[i].occ);
      chk($sformatf("v%0d_in_ready", i), in_ready1, tv[i].ir);
      chk($sformatf("v%0d_out_ctrl", i), out_ctrl1, tv[i].ov ? ctrl_of(tv[i].opc) : 22'h0);
      if (tv[i].ov) begin
        chk($sformatf("v%0d_out_pc", i), out_pc1, tv[i].opc);
        chk($sformatf("v%0d_out_a", i), out_a1, a_of(tv[i].opc));
        chk($sformatf("v%0d_out_b", i), out_b1, b_of(tv[i].opc));
        chk($sformatf("v%0d_out_pb", i), out_pb1, pb_of(tv[i].opc));
        chk($sformatf("v%0d_out_imm", i), out_imm1, imm_of(tv[i].opc));
      end
    end

    // flat build: ready looks through to out_ready, replacement on the same edge
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 9'd0);
    tick();
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 9'd20);
    tick();
    chk("flat_load_valid", out_valid0, 1);
    chk("flat_load_pc", out_pc0, 20);
    chk("flat_load_occ", occ0, 1);
    chk("flat_stall_ready", in_ready0, 0);
    drive(1'b1, 1'b0, 1'b0, 9'd22);
    tick();
    chk("flat_hold_pc", out_pc0, 20);
    chk("flat_hold_ctrl", out_ctrl0, ctrl_of(9'd20));
    drive(1'b1, 1'b1, 1'b0, 9'd21);
    #1;
    chk("flat_ready_comb", in_ready0, 1);
    tick();
    chk("flat_replace_pc", out_pc0, 21);
    chk("flat_replace_a", out_a0, a_of(9'd21));
    chk("flat_replace_occ", occ0, 1);
    drive(1'b0, 1'b1, 1'b0, 9'd0);
    tick();
    chk("flat_drain_valid", out_valid0, 0);
    chk("flat_drain_ctrl", out_ctrl0, 0);
    chk("flat_drain_occ", occ0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
